// File: rtl/cmag_mul_pkg.sv
// cmag_mul_pkg: widths, result-slot type and rotating-priority pick shared by
// the multiplier arbiter and the other shared-resource arbiters of the IP.
package cmag_mul_pkg;

  localparam int A_W     = 25;
  localparam int B_W     = 6;
  localparam int P_W     = A_W + B_W;
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  typedef struct packed {
    logic             vld;
    logic [PTR_W-1:0] id;
    logic [P_W-1:0]   data;
  } res_slot_t;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } pick_t;

  // First set bit of req[n-1:0] scanning upward from ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [PTR_W-1:0]   ptr,
                                    input int                 n);
    pick_t res;
    int    j;
    res = '0;
    // Scan from the far end so the nearest candidate is written last and wins.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && req[j]) begin
        res.found = 1'b1;
        res.idx   = PTR_W'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cmag_rr_pick.sv
// cmag_rr_pick: combinational round-robin selector over NREQ request bits,
// highest priority at ptr.
module cmag_rr_pick
  import cmag_mul_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  logic [MAX_REQ-1:0] req_pad;
  pick_t              pick;

  assign req_pad = MAX_REQ'(req);
  assign pick    = rr_pick(req_pad, ptr, NREQ);
  assign idx     = pick.idx;
  assign found   = pick.found;

endmodule

// File: rtl/cmag_mul_arbiter.sv
// cmag_mul_arbiter: round-robin sharing of one unsigned A_W x B_W multiplier
// among NREQ requesters. Define CMAG_MUL_PIPE_EN for an operand stage (latency 2).
module cmag_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int A_W  = cmag_mul_pkg::A_W,
  parameter int B_W  = cmag_mul_pkg::B_W,
  parameter int P_W  = cmag_mul_pkg::P_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [P_W-1:0]    rsp_data,
  output logic [31:0]       issue_cnt
);
  import cmag_mul_pkg::*;

  function automatic logic [P_W-1:0] mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    return P_W'(a) * P_W'(b);
  endfunction

  res_slot_t        slot;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] g_idx;
  logic             g_found;
  logic             free;
  logic             grant_ok;
  logic             accept;
  logic [A_W-1:0]   grant_a;
  logic [B_W-1:0]   grant_b;

  cmag_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .idx   (g_idx),
    .found (g_found)
  );

  assign free    = !slot.vld || rsp_ready[slot.id];
  assign grant_a = req_a[int'(g_idx)*A_W +: A_W];
  assign grant_b = req_b[int'(g_idx)*B_W +: B_W];
  assign ptr_nxt = (int'(g_idx) == NREQ - 1) ? '0 : g_idx + PTR_W'(1);

`ifdef CMAG_MUL_PIPE_EN
  logic             s1_vld;
  logic [PTR_W-1:0] s1_id;
  logic [A_W-1:0]   s1_a;
  logic [B_W-1:0]   s1_b;

  assign grant_ok = !s1_vld || free;
`else
  assign grant_ok = free;
`endif

  // Reset gates the handshake so req_ready drops at once, not at the next edge.
  assign accept = grant_ok && g_found && !ap_rst;

  always_comb begin
    // NOTE: every output gets a default before the conditional update; a path
    // that leaves it unassigned would infer a latch.
    req_ready = '0;
    rsp_valid = '0;
    if (accept)   req_ready[g_idx]  = 1'b1;
    if (slot.vld) rsp_valid[slot.id] = 1'b1;
  end

  assign rsp_data = slot.data;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      // NOTE: the datapath registers are reset too, because rsp_data has a
      // defined reset value; only pure storage arrays would be left unreset.
      slot      <= '0;
      ptr       <= '0;
      issue_cnt <= '0;
`ifdef CMAG_MUL_PIPE_EN
      s1_vld    <= 1'b0;
      s1_id     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (accept) begin
        ptr       <= ptr_nxt;
        issue_cnt <= issue_cnt + 32'd1;
      end
`ifdef CMAG_MUL_PIPE_EN
      if (free) begin
        slot.vld <= s1_vld;
        if (s1_vld) begin
          slot.id   <= s1_id;
          slot.data <= mul(s1_a, s1_b);
        end
      end
      if (free || !s1_vld) begin
        s1_vld <= accept;
        if (accept) begin
          s1_id <= g_idx;
          s1_a  <= grant_a;
          s1_b  <= grant_b;
        end
      end
`else
      if (free) begin
        slot.vld <= accept;
        if (accept) begin
          slot.id   <= g_idx;
          slot.data <= mul(grant_a, grant_b);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_cmag_mul_arbiter.sv
// tb_cmag_mul_arbiter: directed test of the shared-multiplier arbiter with
// hand-computed products; latency follows CMAG_MUL_PIPE_EN.
module tb_cmag_mul_arbiter;

`ifdef CMAG_MUL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [99:0] req_a = '0;
  logic [23:0] req_b = '0;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready = '0;
  logic [30:0] rsp_data;
  logic [31:0] issue_cnt;

  logic [24:0] op_a [4];
  logic [5:0]  op_b [4];
  logic [30:0] exp_p [4];

  int n_cmp = 0;
  int n_err = 0;

  cmag_mul_arbiter #(.NREQ(4)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .issue_cnt (issue_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*25 +: 25] = op_a[i];
      req_b[i*6 +: 6]   = op_b[i];
    end
  endtask

  // Standard operand set: products 0xBB8, 0xB60B5C, 0x20000000, 0x1B9.
  task automatic load_std_ops();
    op_a  = '{25'd1000, 25'h123456, 25'h1000000, 25'd7};
    op_b  = '{6'd3, 6'd10, 6'd32, 6'd63};
    exp_p = '{31'h0000BB8, 31'h0B60B5C, 31'h20000000, 31'h00001B9};
    drive_ops();
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    #1 ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b0;
    #1 ap_rst = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    #2;
    n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready: observed %h required 0", req_ready); end
    n_cmp++; if (rsp_valid !== 4'h0) begin n_err++; $display("FAIL reset_rsp_valid: observed %h required 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 31'h0) begin n_err++; $display("FAIL reset_rsp_data: observed %h required 0", rsp_data); end
    n_cmp++; if (issue_cnt !== 32'h0) begin n_err++; $display("FAIL reset_issue_cnt: observed %h required 0", issue_cnt); end
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    op_a[0] = 25'h1FFFFFF;
    op_b[0] = 6'h3F;
    drive_ops();
    req_valid = 4'b0001;
    rsp_ready = 4'hF;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: observed %b required 0001", req_ready); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_idle: observed %b required 0000", rsp_valid); end
    tick();
    req_valid = '0;
    repeat (LAT - 1) tick();
    #1;
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL single_rsp_valid: observed %b required 0001", rsp_valid); end
    n_cmp++; if (rsp_data !== 31'h7DFFFFC1) begin n_err++; $display("FAIL single_rsp_data: observed %h required 7dffffc1", rsp_data); end
    n_cmp++; if (issue_cnt !== 32'd1) begin n_err++; $display("FAIL single_issue_cnt: observed %0d required 1", issue_cnt); end
    tick();
    #1;
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_drain: observed %b required 0000", rsp_valid); end
    n_cmp++; if (rsp_data !== 31'h7DFFFFC1) begin n_err++; $display("FAIL single_hold_data: observed %h required 7dffffc1", rsp_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    logic [3:0] exp_vld;
    int         o;
    do_reset();
    load_std_ops();
    rsp_ready = 4'hF;
    for (int t = 0; t < 8 + LAT; t++) begin
      req_valid = (t < 8) ? 4'hF : 4'h0;
      #1;
      exp_ready = (t < 8) ? (4'b0001 << (t % 4)) : 4'b0000;
      n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rr_ready[%0d]: observed %b required %b", t, req_ready, exp_ready); end
      if (t >= LAT) begin
        o = (t - LAT) % 4;
        exp_vld = 4'b0001 << o;
        n_cmp++; if (rsp_valid !== exp_vld) begin n_err++; $display("FAIL rr_rsp_valid[%0d]: observed %b required %b", t, rsp_valid, exp_vld); end
        n_cmp++; if (rsp_data !== exp_p[o]) begin n_err++; $display("FAIL rr_rsp_data[%0d]: observed %h required %h", t, rsp_data, exp_p[o]); end
      end
      tick();
    end
    #1;
    n_cmp++; if (issue_cnt !== 32'd8) begin n_err++; $display("FAIL rr_issue_cnt: observed %0d required 8", issue_cnt); end
  endtask

  task automatic test_stall();
    logic [3:0] exp_ready;
    do_reset();
    load_std_ops();
    req_valid = 4'b0100;
    rsp_ready = 4'b1011;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_first_grant: observed %b required 0100", req_ready); end
    tick();
    repeat (LAT - 1) begin
      req_valid = 4'b0000;
      tick();
    end
    req_valid = 4'b1011;
    for (int s = 0; s < 5; s++) begin
      #1;
      // With the operand stage, one further grant fills it before the stall bites.
      exp_ready = (LAT == 2 && s == 0) ? 4'b1000 : 4'b0000;
      n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL stall_ready[%0d]: observed %b required %b", s, req_ready, exp_ready); end
      n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL stall_rsp_valid[%0d]: observed %b required 0100", s, rsp_valid); end
      n_cmp++; if (rsp_data !== 31'h20000000) begin n_err++; $display("FAIL stall_rsp_data[%0d]: observed %h required 20000000", s, rsp_data); end
      tick();
    end
    rsp_ready = 4'hF;
    #1;
    exp_ready = (LAT == 1) ? 4'b1000 : 4'b0001;
    n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL release_ready: observed %b required %b", req_ready, exp_ready); end
    n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL release_rsp_valid: observed %b required 0100", rsp_valid); end
    tick();
    #1;
    exp_ready = (LAT == 1) ? 4'b0001 : 4'b0010;
    n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL after_release_ready: observed %b required %b", req_ready, exp_ready); end
    n_cmp++; if (rsp_valid !== 4'b1000) begin n_err++; $display("FAIL after_release_valid: observed %b required 1000", rsp_valid); end
    n_cmp++; if (rsp_data !== 31'h1B9) begin n_err++; $display("FAIL after_release_data: observed %h required 1b9", rsp_data); end
    n_cmp++; if (issue_cnt !== 32'(LAT + 1)) begin n_err++; $display("FAIL stall_issue_cnt: observed %0d required %0d", issue_cnt, LAT + 1); end
    tick();
    req_valid = '0;
    #1;
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL stall_third_valid: observed %b required 0001", rsp_valid); end
    n_cmp++; if (rsp_data !== 31'hBB8) begin n_err++; $display("FAIL stall_third_data: observed %h required bb8", rsp_data); end
    tick();
  endtask

  task automatic test_ptr_wrap();
    logic [3:0]  vseq [5];
    logic [3:0]  rseq [5];
    int          order [3];
    logic [30:0] odata [3];
    logic [3:0]  exp_vld;
    do_reset();
    op_a = '{25'd999, 25'd0, 25'h1000000, 25'd12345};
    op_b = '{6'd1, 6'd5, 6'd32, 6'd0};
    drive_ops();
    vseq  = '{4'b0100, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
    rseq  = '{4'b0100, 4'b1000, 4'b0010, 4'b0000, 4'b0000};
    order = '{2, 3, 1};
    odata = '{31'h20000000, 31'h0, 31'h0};
    rsp_ready = 4'hF;
    for (int t = 0; t < 5; t++) begin
      req_valid = vseq[t];
      #1;
      n_cmp++; if (req_ready !== rseq[t]) begin n_err++; $display("FAIL wrap_ready[%0d]: observed %b required %b", t, req_ready, rseq[t]); end
      if (t >= LAT && t - LAT < 3) begin
        exp_vld = 4'b0001 << order[t-LAT];
        n_cmp++; if (rsp_valid !== exp_vld) begin n_err++; $display("FAIL wrap_rsp_valid[%0d]: observed %b required %b", t, rsp_valid, exp_vld); end
        n_cmp++; if (rsp_data !== odata[t-LAT]) begin n_err++; $display("FAIL wrap_rsp_data[%0d]: observed %h required %h", t, rsp_data, odata[t-LAT]); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_vld;
    do_reset();
    load_std_ops();
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    repeat (3) tick();
    #1;
    exp_vld = 4'b0001 << (3 - LAT);
    n_cmp++; if (issue_cnt !== 32'd3) begin n_err++; $display("FAIL burst_issue_cnt: observed %0d required 3", issue_cnt); end
    n_cmp++; if (rsp_valid !== exp_vld) begin n_err++; $display("FAIL burst_rsp_valid: observed %b required %b", rsp_valid, exp_vld); end
    ap_rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL async_req_ready: observed %b required 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 4'h0) begin n_err++; $display("FAIL async_rsp_valid: observed %b required 0000", rsp_valid); end
    n_cmp++; if (issue_cnt !== 32'h0) begin n_err++; $display("FAIL async_issue_cnt: observed %0d required 0", issue_cnt); end
    n_cmp++; if (rsp_data !== 31'h0) begin n_err++; $display("FAIL async_rsp_data: observed %h required 0", rsp_data); end
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL post_reset_priority: observed %b required 0001", req_ready); end
    tick();
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_ptr_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
